// File: rtl/airlock_sequencer_pkg.sv
// rtl/airlock_sequencer_pkg.sv - state codes, pass direction and helpers for the airlock sequencer
package airlock_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VENT     = 3'd1,
    ST_OPEN_OUT = 3'd2,
    ST_PRESS    = 3'd3,
    ST_OPEN_IN  = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  localparam logic DIR_ARRIVE = 1'b0;
  localparam logic DIR_DEPART = 1'b1;

  function automatic logic is_pump(input state_t s);
    return (s == ST_VENT) || (s == ST_PRESS);
  endfunction

endpackage

// File: rtl/airlock_sequencer_tick_gen.sv
// rtl/airlock_sequencer_tick_gen.sv - timing prescaler, one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/airlock_sequencer.sv
// rtl/airlock_sequencer.sv - airlock pass sequencer: door interlock, pump/vent countdown, latched fault
module airlock_sequencer
  import airlock_sequencer_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int CNT_W        = 8,
  parameter int PRESS_TICKS  = 5,
  parameter int VENT_TICKS   = 8,
  parameter int CHAMBER_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arrive_req,
  input  logic             depart_req,
  input  logic             outer_sw,
  input  logic             inner_sw,
  output logic             outer_en,
  output logic             inner_en,
  output logic             chamber_hi,
  output logic             wait_var,
  output logic             finished_var,
  output logic             fault,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] PRESS_CNT = CNT_W'(PRESS_TICKS);
  localparam logic [CNT_W-1:0] VENT_CNT  = CNT_W'(VENT_TICKS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic             INIT_HI   = (CHAMBER_INIT != 0);

  state_t           state, state_n;
  logic             dir, dir_n;
  logic             chamber_n;
  logic [CNT_W-1:0] rem_n;
  logic             seen_open, seen_n;
  logic             tick, clr, viol;

  // Enables are registered, so a sensor checked against them sees what the door was actually told.
  assign viol = (outer_sw & ~outer_en) | (inner_sw & ~inner_en);
  assign clr  = (state_n != state);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    state_n   = state;
    dir_n     = dir;
    chamber_n = chamber_hi;
    rem_n     = remaining;
    seen_n    = seen_open;
    if (viol || state == ST_FAULT) begin
      state_n = ST_FAULT;
      rem_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rem_n  = '0;
          seen_n = 1'b0;
          if (arrive_req) begin
            dir_n   = DIR_ARRIVE;
            state_n = chamber_hi ? ST_VENT : ST_OPEN_OUT;
          end else if (depart_req) begin
            dir_n   = DIR_DEPART;
            state_n = chamber_hi ? ST_OPEN_IN : ST_PRESS;
          end
        end
        ST_VENT: begin
          if (tick) begin
            if (remaining == ONE) begin
              rem_n     = '0;
              chamber_n = 1'b0;
              state_n   = ST_OPEN_OUT;
            end else begin
              rem_n = remaining - ONE;
            end
          end
        end
        ST_PRESS: begin
          if (tick) begin
            if (remaining == ONE) begin
              rem_n     = '0;
              chamber_n = 1'b1;
              state_n   = ST_OPEN_IN;
            end else begin
              rem_n = remaining - ONE;
            end
          end
        end
        ST_OPEN_OUT: begin
          if (outer_sw) begin
            seen_n = 1'b1;
          end else if (seen_open) begin
            seen_n  = 1'b0;
            state_n = (dir == DIR_ARRIVE) ? ST_PRESS : ST_DONE;
          end
        end
        ST_OPEN_IN: begin
          if (inner_sw) begin
            seen_n = 1'b1;
          end else if (seen_open) begin
            seen_n  = 1'b0;
            state_n = (dir == DIR_ARRIVE) ? ST_DONE : ST_VENT;
          end
        end
        ST_DONE:  state_n = ST_IDLE;
        default:  state_n = ST_FAULT;
      endcase
      // Countdown is loaded on entry so the first value is visible for a whole tick period.
      if (state_n != state && state_n == ST_VENT)  rem_n = VENT_CNT;
      if (state_n != state && state_n == ST_PRESS) rem_n = PRESS_CNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      dir          <= DIR_ARRIVE;
      chamber_hi   <= INIT_HI;
      remaining    <= '0;
      seen_open    <= 1'b0;
      outer_en     <= 1'b0;
      inner_en     <= 1'b0;
      wait_var     <= 1'b0;
      finished_var <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_n;
      dir          <= dir_n;
      chamber_hi   <= chamber_n;
      remaining    <= rem_n;
      seen_open    <= seen_n;
      outer_en     <= (state_n == ST_OPEN_OUT);
      inner_en     <= (state_n == ST_OPEN_IN);
      wait_var     <= is_pump(state_n);
      finished_var <= (state_n == ST_DONE);
      fault        <= (state_n == ST_FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb/tb_airlock_sequencer.sv - self-checking bench for airlock_sequencer
module tb_airlock_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arrive = 1'b0, depart = 1'b0, osw = 1'b0, isw = 1'b0;
  logic sel = 1'b0;

  logic       a_oen, a_ien, a_ch, a_wait, a_fin, a_flt;
  logic [7:0] a_rem;
  logic [2:0] a_st;
  logic       b_oen, b_ien, b_ch, b_wait, b_fin, b_flt;
  logic [7:0] b_rem;
  logic [2:0] b_st;

  logic       o_oen, o_ien, o_ch, o_wait, o_fin, o_flt;
  logic [7:0] o_rem;
  logic [2:0] o_st;

  int checks = 0;
  int errors = 0;
  int div = 1;
  int m_ch [2];

  typedef struct {int code; int ticks;} phase_t;
  phase_t plan[$];

  always #5 clk = ~clk;

  airlock_sequencer #(.TICK_DIV(1), .CNT_W(8), .PRESS_TICKS(4), .VENT_TICKS(3), .CHAMBER_INIT(0)) dut_a (
    .clk(clk), .rst(rst),
    .arrive_req(arrive & ~sel), .depart_req(depart & ~sel),
    .outer_sw(osw & ~sel), .inner_sw(isw & ~sel),
    .outer_en(a_oen), .inner_en(a_ien), .chamber_hi(a_ch), .wait_var(a_wait),
    .finished_var(a_fin), .fault(a_flt), .remaining(a_rem), .state_o(a_st)
  );

  airlock_sequencer #(.TICK_DIV(4), .CNT_W(8), .PRESS_TICKS(4), .VENT_TICKS(3), .CHAMBER_INIT(0)) dut_b (
    .clk(clk), .rst(rst),
    .arrive_req(arrive & sel), .depart_req(depart & sel),
    .outer_sw(osw & sel), .inner_sw(isw & sel),
    .outer_en(b_oen), .inner_en(b_ien), .chamber_hi(b_ch), .wait_var(b_wait),
    .finished_var(b_fin), .fault(b_flt), .remaining(b_rem), .state_o(b_st)
  );

  assign o_oen  = sel ? b_oen  : a_oen;
  assign o_ien  = sel ? b_ien  : a_ien;
  assign o_ch   = sel ? b_ch   : a_ch;
  assign o_wait = sel ? b_wait : a_wait;
  assign o_fin  = sel ? b_fin  : a_fin;
  assign o_flt  = sel ? b_flt  : a_flt;
  assign o_rem  = sel ? b_rem  : a_rem;
  assign o_st   = sel ? b_st   : a_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    assert (((a_oen & a_ien) | (b_oen & b_ien)) !== 1'b1) else begin
      errors++;
      $error("FAIL interlock: observed both enables 1 expected never both");
    end
  endtask

  // Expected phase list for a pass, derived from direction and current chamber pressure.
  task automatic build_plan(input bit arrival);
    plan.delete();
    if (arrival) begin
      if (m_ch[sel] != 0) plan.push_back('{1, 3});
      plan.push_back('{2, 0});
      plan.push_back('{3, 4});
      plan.push_back('{4, 0});
    end else begin
      if (m_ch[sel] == 0) plan.push_back('{3, 4});
      plan.push_back('{4, 0});
      plan.push_back('{1, 3});
      plan.push_back('{2, 0});
    end
    plan.push_back('{5, 0});
  endtask

  task automatic door_phase(input int code);
    int dwell;
    chk("door_state", o_st, code);
    chk("door_outer_en", o_oen, code == 2);
    chk("door_inner_en", o_ien, code == 4);
    chk("door_wait", o_wait, 0);
    chk("door_rem", o_rem, 0);
    dwell = $urandom_range(0, 2);
    for (int i = 0; i < dwell; i++) begin
      step();
      chk("door_hold_closed", o_st, code);
    end
    if (code == 2) osw = 1'b1; else isw = 1'b1;
    step();
    chk("door_hold_open", o_st, code);
    dwell = $urandom_range(0, 2);
    for (int i = 0; i < dwell; i++) begin
      step();
      chk("door_hold_open2", o_st, code);
    end
    osw = 1'b0;
    isw = 1'b0;
    step();
  endtask

  task automatic pump_phase(input int code, input int n);
    chk("pump_state", o_st, code);
    chk("pump_wait", o_wait, 1);
    chk("pump_en", {o_oen, o_ien}, 0);
    chk("pump_chamber_before", o_ch, m_ch[sel]);
    for (int k = n; k >= 1; k--) begin
      for (int c = 0; c < div; c++) begin
        chk("pump_rem", o_rem, k);
        step();
      end
    end
    m_ch[sel] = (code == 3);
    chk("pump_chamber_after", o_ch, m_ch[sel]);
  endtask

  task automatic run_pass(input bit arrival, input bit both);
    build_plan(arrival);
    chk("pass_idle", o_st, 0);
    arrive = arrival | both;
    depart = ~arrival | both;
    step();
    arrive = 1'b0;
    depart = 1'b0;
    foreach (plan[i]) begin
      case (plan[i].code)
        1, 3: pump_phase(plan[i].code, plan[i].ticks);
        2, 4: door_phase(plan[i].code);
        default: begin
          chk("done_state", o_st, 5);
          chk("done_pulse", o_fin, 1);
          step();
          chk("done_pulse_end", o_fin, 0);
          chk("done_idle", o_st, 0);
        end
      endcase
    end
    chk("pass_chamber", o_ch, m_ch[sel]);
  endtask

  initial begin
    bit d;
    m_ch[0] = 0;
    m_ch[1] = 0;
    @(posedge clk);
    #1;
    chk("rst_state", a_st, 0);
    chk("rst_chamber", a_ch, 0);
    chk("rst_rem", a_rem, 0);
    chk("rst_outs", {a_oen, a_ien, a_wait, a_fin, a_flt}, 0);
    chk("rst_state_b", b_st, 0);
    rst = 1'b0;
    step();

    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b0);
    run_pass(1'b1, 1'b1);
    chk("both_req_arrival_chamber", o_ch, 1);
    repeat (8) begin
      d = 1'($urandom_range(0, 1));
      run_pass(d, d & 1'($urandom_range(0, 1)));
    end
    if (m_ch[0] == 0) run_pass(1'b1, 1'b0);

    isw = 1'b1;
    step();
    chk("fault_flag", o_flt, 1);
    chk("fault_state", o_st, 6);
    chk("fault_en", {o_oen, o_ien}, 0);
    chk("fault_rem", o_rem, 0);
    chk("fault_chamber_held", o_ch, 1);
    isw = 1'b0;
    arrive = 1'b1;
    repeat (3) step();
    chk("fault_sticky", o_st, 6);
    arrive = 1'b0;
    depart = 1'b1;
    step();
    chk("fault_sticky2", o_st, 6);
    depart = 1'b0;
    rst = 1'b1;
    #1;
    chk("fault_rst_state", o_st, 0);
    chk("fault_rst_chamber", o_ch, 0);
    chk("fault_rst_flag", o_flt, 0);
    @(negedge clk);
    rst = 1'b0;
    m_ch[0] = 0;
    m_ch[1] = 0;
    step();

    arrive = 1'b1;
    step();
    arrive = 1'b0;
    door_phase(2);
    chk("midrst_press", o_st, 3);
    step();
    step();
    chk("midrst_rem2", o_rem, 2);
    rst = 1'b1;
    #1;
    chk("midrst_wait", o_wait, 0);
    chk("midrst_rem", o_rem, 0);
    chk("midrst_chamber", o_ch, 0);
    chk("midrst_state", o_st, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    sel = 1'b1;
    div = 4;
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b0);
    chk("div4_a_idle", a_st, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
